mips_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_shifter.sv | 32 +++
 rtl/mips_alu.sv | 92 +++++++++
 tb/tb_mips_alu.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Control codes and shared types for the mips_alu execute-stage ALU.
package alu_pkg;

  localparam int ALU_CTRL_W = 5;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 5'b00000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 5'b00001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 5'b00010;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 5'b00011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 5'b00100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 5'b00101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 5'b00110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 5'b00111;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 5'b01000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 5'b01001;
  localparam logic [ALU_CTRL_W-1:0] ALU_LUI  = 5'b01010;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR  = 5'b01100;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational log-stage barrel shifter for SLL/SRL/SRA.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [SW-1:0]    shamt,
  input  shift_mode_e      mode,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] v;

  // Stage i shifts by 2**i when shamt[i] is set.
  always_comb begin
    v = value;
    for (int i = 0; i < SW; i++) begin
      if (shamt[i]) begin
        case (mode)
          SH_SLL:  v = v << (1 << i);
          SH_SRL:  v = v >> (1 << i);
          SH_SRA:  v = $signed(v) >>> (1 << i);
          default: v = v;
        endcase
      end
    end
    result = v;
  end

endmodule

// File: rtl/mips_alu.sv
// Registered MIPS execute-stage ALU; define ALU_FLAGS_EN to add zero/ovf outputs.
module mips_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in1,
  input  logic [WIDTH-1:0]      in2,
  input  logic [ALU_CTRL_W-1:0] ctrl,
  output logic [WIDTH-1:0]      out
`ifdef ALU_FLAGS_EN
  ,
  output logic                  zero,
  output logic                  ovf
`endif
);

  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] sum, diff, shifted, nxt;
  logic             lt_s, lt_u;
  shift_mode_e      smode;

  assign sum  = in1 + in2;
  assign diff = in1 - in2;
  assign lt_u = in1 < in2;
  // Differing signs decide directly, so the compare never relies on a wrapped difference.
  assign lt_s = (in1[MSB] != in2[MSB]) ? in1[MSB] : lt_u;

  always_comb begin
    smode = SH_SLL;
    if (ctrl == ALU_SRL) smode = SH_SRL;
    else if (ctrl == ALU_SRA) smode = SH_SRA;
  end

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .value (in2),
    .shamt (in1[SW-1:0]),
    .mode  (smode),
    .result(shifted)
  );

  always_comb begin
    nxt = '0;
    case (ctrl)
      ALU_AND:  nxt = in1 & in2;
      ALU_OR:   nxt = in1 | in2;
      ALU_ADD:  nxt = sum;
      ALU_XOR:  nxt = in1 ^ in2;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  nxt = shifted;
      ALU_SUB:  nxt = diff;
      ALU_SLT:  nxt = {{(WIDTH-1){1'b0}}, lt_s};
      ALU_SLTU: nxt = {{(WIDTH-1){1'b0}}, lt_u};
      ALU_LUI:  nxt = {in2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      ALU_NOR:  nxt = ~(in1 | in2);
      default:  nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else        out <= nxt;
  end

`ifdef ALU_FLAGS_EN
  logic ovf_nxt;

  always_comb begin
    ovf_nxt = 1'b0;
    if (ctrl == ALU_ADD)
      ovf_nxt = (in1[MSB] == in2[MSB]) && (sum[MSB] != in1[MSB]);
    else if (ctrl == ALU_SUB)
      ovf_nxt = (in1[MSB] != in2[MSB]) && (diff[MSB] != in1[MSB]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      zero <= (nxt == '0);
      ovf  <= ovf_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed cases plus randomized ops against a behavioural model.
module tb_mips_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in1, in2;
  logic [4:0]  ctrl;
  logic [31:0] out;
`ifdef ALU_FLAGS_EN
  logic        zero, ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  mips_alu #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in1  (in1),
    .in2  (in2),
    .ctrl (ctrl),
    .out  (out)
`ifdef ALU_FLAGS_EN
    ,
    .zero (zero),
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = a % 32;
    case (c)
      5'd0:    return a & b;
      5'd1:    return a | b;
      5'd2:    return a + b;
      5'd3:    return a ^ b;
      5'd4:    return b << sh;
      5'd5:    return b >> sh;
      5'd8:    return $signed(b) >>> sh;
      5'd6:    return a - b;
      5'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd9:    return (a < b) ? 32'd1 : 32'd0;
      5'd10:   return {b[15:0], 16'h0000};
      5'd12:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (c == 5'd2)      s = longint'($signed(a)) + longint'($signed(b));
    else if (c == 5'd6) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, check #1 after the capturing rising edge.
  task automatic step(input string tag, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e;
    @(negedge clk);
    ctrl = c; in1 = a; in2 = b;
    e = model(c, a, b);
    @(posedge clk);
    #1;
    check(tag, out, e);
`ifdef ALU_FLAGS_EN
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, e == 32'd0});
    check({tag, ".ovf"},  {31'd0, ovf},  {31'd0, model_ovf(c, a, b)});
`endif
  endtask

  localparam logic [4:0] valid_codes [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5,
                                              5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd12};

  initial begin
    logic [4:0]  c;
    logic [31:0] a, b;
    rst_n = 1'b0; in1 = '0; in2 = '0; ctrl = '0;
    #3;
    check("reset_out", out, 32'd0);
`ifdef ALU_FLAGS_EN
    check("reset_zero", {31'd0, zero}, 32'd0);
    check("reset_ovf",  {31'd0, ovf},  32'd0);
`endif
    #9 rst_n = 1'b1;

    step("add_3_1", 5'b00010, 32'd3, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", out, 32'd0);
    @(posedge clk); #1;
    check("reset_held", out, 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    step("and_after_reset", 5'b00000, 32'd3, 32'd1);

    step("or",  5'b00001, 32'd3, 32'd1);
    step("add", 5'b00010, 32'd3, 32'd1);
    step("sub", 5'b00110, 32'd3, 32'd1);
    step("slt", 5'b00111, 32'd3, 32'd1);
    step("nor", 5'b01100, 32'd3, 32'd1);
    check("nor_literal", out, 32'hFFFF_FFFC);

    step("slt_extreme",  5'b00111, 32'h8000_0000, 32'h7FFF_FFFF);
    check("slt_extreme_literal", out, 32'd1);
    step("sltu_extreme", 5'b01001, 32'h8000_0000, 32'h7FFF_FFFF);
    step("sub_extreme",  5'b00110, 32'h8000_0000, 32'h7FFF_FFFF);
    check("sub_extreme_literal", out, 32'd1);
    step("slt_equal",    5'b00111, 32'h1234_5678, 32'h1234_5678);

    step("sll_33", 5'b00100, 32'h21, 32'h8000_0001);
    check("sll_33_literal", out, 32'h0000_0002);
    step("srl_33", 5'b00101, 32'h21, 32'h8000_0001);
    check("srl_33_literal", out, 32'h4000_0000);
    step("sra_33", 5'b01000, 32'h21, 32'h8000_0001);
    check("sra_33_literal", out, 32'hC000_0000);
    step("sra_31", 5'b01000, 32'h1F, 32'h8000_0000);

    step("lui",        5'b01010, 32'h0, 32'h0000_1234);
    check("lui_literal", out, 32'h1234_0000);
    step("undef_1f",   5'b11111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step("undef_0b",   5'b01011, 32'hFFFF_FFFF, 32'h1);
    step("undef_0d",   5'b01101, 32'hFFFF_FFFF, 32'h1);
    step("add_wrap",   5'b00010, 32'hFFFF_FFFF, 32'h1);
    check("add_wrap_literal", out, 32'd0);
    step("add_ovf",    5'b00010, 32'h7FFF_FFFF, 32'h1);
    step("xor",        5'b00011, 32'hA5A5_0F0F, 32'hFFFF_0000);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) c = 5'($urandom_range(0, 31));
      else c = valid_codes[$urandom_range(0, 11)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = {a[31], 31'h0} | 32'($urandom_range(0, 3));
      step("random", c, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
